// File: rtl/rf_sb_param.sv
// NREGS x WIDTH register file with two operand read ports, a destination read port,
// one write port, optional write-to-read bypass, optional zero R0 and a pending-write scoreboard.
module rf_sb_param #(
    parameter int NREGS   = 8,
    parameter int WIDTH   = 16,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             sclr,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] opD,
    output logic             busy_a,
    output logic             busy_b,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec,
    inout  wire              dvdd,
    inout  wire              dgnd
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [WIDTH-1:0] r [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_valid;
    logic             iss_valid;
    logic             hit_a;
    logic             hit_b;

    // Addresses past the last register, and R0 when hardwired, behave as a sink.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    assign wr_valid  = rstz && !sclr && en && addr_ok(rd);
    assign iss_valid = rstz && !sclr && iss_en && addr_ok(iss_rd);
    assign hit_a     = (BYPASS != 0) && wr_valid && (rd == ra);
    assign hit_b     = (BYPASS != 0) && wr_valid && (rd == rb);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
            busy <= '0;
        end else if (sclr) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_valid && (rd == AW'(i))) r[i] <= data;
                // A new producer issuing in the writeback cycle keeps the register pending.
                if (iss_valid && (iss_rd == AW'(i))) busy[i] <= 1'b1;
                else if (wr_valid && (rd == AW'(i))) busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        opA    = '0;
        opB    = '0;
        opD    = '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (rstz) begin
            if (addr_ok(ra)) begin
                opA    = r[ra];
                busy_a = busy[ra];
            end
            if (addr_ok(rb)) begin
                opB    = r[rb];
                busy_b = busy[rb];
            end
            if (hit_a) begin
                opA    = data;
                busy_a = 1'b0;
            end
            if (hit_b) begin
                opB    = data;
                busy_b = 1'b0;
            end
            if (addr_ok(rd)) opD = r[rd];
        end
    end

    assign stall    = busy_a | busy_b;
    assign busy_vec = busy;

endmodule
